// File: rtl/traffic_ctrl_param.sv
// Highway/country-road signal sequencer with parameterised phase timing.
// Optional pedestrian request path enabled by defining PED_REQ_EN.
module traffic_ctrl_param #(
   parameter int CNT_W           = 8,
   parameter int HWY_MIN_GREEN   = 6,
   parameter int CNTRY_MAX_GREEN = 10,
   parameter int Y2RDELAY        = 3,
   parameter int R2GDELAY        = 2
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       X,
`ifdef PED_REQ_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic [2:0] state
);

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;

   localparam int TMAX = (1 << CNT_W);

   localparam bit BAD_PARAM =
      (HWY_MIN_GREEN   < 1) || (HWY_MIN_GREEN   >= TMAX) ||
      (CNTRY_MAX_GREEN < 1) || (CNTRY_MAX_GREEN >= TMAX) ||
      (Y2RDELAY        < 1) || (Y2RDELAY        >= TMAX) ||
      (R2GDELAY        < 1) || (R2GDELAY        >= TMAX);

   generate
      if (BAD_PARAM) begin : g_bad_param
         $error("traffic_ctrl_param: timing parameters must be in [1, 2**CNT_W-1]");
      end
   endgenerate

   // Timer value seen at the deciding edge of the last cycle of each phase
   localparam logic [CNT_W-1:0] HMG_L = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CMG_L = CNT_W'(CNTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] Y_L   = CNT_W'(Y2RDELAY - 1);
   localparam logic [CNT_W-1:0] R_L   = CNT_W'(R2GDELAY - 1);

   logic [CNT_W-1:0] timer;
   logic [2:0]       state_d;
   logic [1:0]       hwy_d, cntry_d;
   logic             go_x, cg_end;

`ifdef PED_REQ_EN
   localparam int               PED_MIN = (CNTRY_MAX_GREEN < 4) ? CNTRY_MAX_GREEN : 4;
   localparam logic [CNT_W-1:0] PED_L   = CNT_W'(PED_MIN - 1);

   logic req, req_d, walk_d;

   // A latched request forces the highway to yield and pins country green
   // for the pedestrian minimum even if cars leave.
   assign go_x   = X | req;
   assign cg_end = (timer >= CMG_L) | (~X & ~(req & (timer < PED_L)));
   assign req_d  = ped_req | (req & ~((state == S3) && (state_d == S4)));
   assign walk_d = (state_d == S3) & req_d;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         req  <= 1'b0;
         walk <= 1'b0;
      end else begin
         req  <= req_d;
         walk <= walk_d;
      end
   end
`else
   assign go_x   = X;
   assign cg_end = (timer >= CMG_L) | ~X;
`endif

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= S0;
         timer <= '0;
         hwy   <= GREEN;
         cntry <= RED;
      end else begin
         state <= state_d;
         hwy   <= hwy_d;
         cntry <= cntry_d;
         if (state_d != state)
            timer <= '0;
         else if (!(&timer))
            timer <= timer + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S0:      if (go_x && (timer >= HMG_L)) state_d = S1;
         S1:      if (timer >= Y_L)             state_d = S2;
         S2:      if (timer >= R_L)             state_d = S3;
         S3:      if (cg_end)                   state_d = S4;
         S4:      if (timer >= Y_L)             state_d = S5;
         S5:      if (timer >= R_L)             state_d = S0;
         default:                               state_d = S0;
      endcase
   end

   // Lights are decoded from the next state so they register with it
   always_comb begin
      hwy_d   = RED;
      cntry_d = RED;
      case (state_d)
         S0:      hwy_d   = GREEN;
         S1:      hwy_d   = YELLOW;
         S3:      cntry_d = GREEN;
         S4:      cntry_d = YELLOW;
         S2, S5:  ;
         default: hwy_d   = GREEN;
      endcase
   end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: phase-level model checked every cycle
// plus hand-computed phase lengths and asynchronous reset values.
module tb_traffic_ctrl_param;

   localparam int HMG = 6;
   localparam int CMG = 10;
   localparam int YD  = 3;
   localparam int RD  = 2;

   logic       clock;
   logic       clear_n;
   logic       x;
   logic [1:0] hwy, cntry;
   logic [2:0] state;
`ifdef PED_REQ_EN
   logic       ped_req;
   logic       walk;
   initial ped_req = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   traffic_ctrl_param #(
      .CNT_W(8), .HWY_MIN_GREEN(HMG), .CNTRY_MAX_GREEN(CMG),
      .Y2RDELAY(YD), .R2GDELAY(RD)
   ) dut (
      .clock  (clock),
      .clear_n(clear_n),
      .X      (x),
`ifdef PED_REQ_EN
      .ped_req(ped_req),
      .walk   (walk),
`endif
      .hwy    (hwy),
      .cntry  (cntry),
      .state  (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Phase model: phase index 0..5 and number of cycles already spent in it
   int ph = 0;
   int el = 0;

   function automatic int exp_hwy(input int p);
      case (p)
         0:       return 2;
         1:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_cntry(input int p);
      case (p)
         3:       return 2;
         4:       return 1;
         default: return 0;
      endcase
   endfunction

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         ph = 0;
         el = 0;
      end else begin
         bit leave;
         case (ph)
            0:       leave = x && (el + 1 >= HMG);
            1, 4:    leave = (el + 1 >= YD);
            2, 5:    leave = (el + 1 >= RD);
            default: leave = !x || (el + 1 >= CMG);
         endcase
         if (leave) begin
            ph = (ph + 1) % 6;
            el = 0;
         end else begin
            el = el + 1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("model_state", int'(state), ph);
         check("model_hwy",   int'(hwy),   exp_hwy(ph));
         check("model_cntry", int'(cntry), exp_cntry(ph));
         check("never_both_go", int'(hwy != 2'd0 && cntry != 2'd0), 0);
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   function automatic int cur(input int sel);
      case (sel)
         0:       return int'(hwy);
         1:       return int'(cntry);
         default: return int'(hwy == 2'd0 && cntry == 2'd0);
      endcase
   endfunction

   // Counts consecutive per-cycle samples (starting now) where cur(sel)==val
   task automatic run_len(input int sel, input int val, output int n);
      n = 0;
      while (cur(sel) == val && n < 100) begin
         n++;
         step();
      end
   endtask

   // Called between a negedge and the following posedge
   task automatic do_reset(input logic xv);
      x       = xv;
      clear_n = 1'b0;
      #1;
      check("rst_hwy",   int'(hwy),   2);
      check("rst_cntry", int'(cntry), 0);
      check("rst_state", int'(state), 0);
      chk_en = 1;
      #1;
      clear_n = 1'b1;
   endtask

   initial begin
      int n;
      clear_n = 1'b1;
      x       = 1'b0;
      step();

      // Reset, then idle with no cars
      do_reset(1'b0);
      repeat (20) @(negedge clock);
      #1;
      check("idle_state", int'(state), 0);
      check("idle_hwy",   int'(hwy),   2);

      // Continuous demand from reset: minimum highway green, max country green
      do_reset(1'b1);
      run_len(0, 2, n); check("hg_min_len", n, 6);
      run_len(0, 1, n); check("hy_len",     n, 3);
      run_len(2, 1, n); check("ar1_len",    n, 2);
      check("cg_start", int'(cntry), 2);
      run_len(1, 2, n); check("cg_max_len", n, 10);
      run_len(1, 1, n); check("cy_len",     n, 3);
      run_len(2, 1, n); check("ar2_len",    n, 2);
      run_len(0, 2, n); check("hg_again_len", n, 6);
      run_len(0, 1, n);
      run_len(2, 1, n);

      // Early exit after 4 country-green cycles, then an ignored X glitch
      repeat (3) step();
      check("cg_before_drop", int'(cntry), 2);
      x = 1'b0;
      step();
      check("cy_after_drop", int'(cntry), 1);
      x = 1'b1;
      step();
      x = 1'b0;
      run_len(1, 1, n); check("cy_rest_len", n, 2);
      run_len(2, 1, n); check("ar2_after_glitch", n, 2);
      check("hg_after_early", int'(hwy), 2);

      // Reset in the middle of country green
      x = 1'b1;
      n = 0;
      while (cntry != 2'd2 && n < 100) begin
         step();
         n++;
      end
      check("reach_cg", int'(cntry), 2);
      step();
      step();
      do_reset(1'b1);
      run_len(0, 2, n); check("hg_after_rst_len", n, 6);
      run_len(0, 1, n);
      run_len(2, 1, n);

      // Car gone on the first country-green edge: one-cycle green
      x = 1'b0;
      run_len(1, 2, n); check("cg_min_len", n, 1);
      run_len(1, 1, n); check("cy_after_min", n, 3);
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
